// File: rtl/pc_pkg.sv
// Shared types for the program counter unit: sequencing states and next-pc source select.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    JMP = 2'd2,
    RET = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras import pc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    tp;
  logic [CW-1:0]    count;

  assign tp    = wp - PW'(1);
  assign top   = mem[tp];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Write pointer wraps naturally, so the slot written when full is the oldest one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      wp    <= tp;
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with boot/run/halt sequencing, branch/jump/call/return redirects.
// state | meaning
// BOOT  | one cycle after reset, pc held, no fetch
// RUN   | fetching; pc advances or redirects unless stalled
// HALT  | pc held, no fetch, waits for resume
module pc_unit import pc_pkg::*; #(
  parameter int                       WIDTH        = 32,
  parameter int                       INCR         = 4,
  parameter logic [WIDTH-1:0]         RESET_VECTOR = '0,
  parameter int                       RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc_plus,
  output logic             misalign,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INCR - 1);

  pc_state_e        state;
  pc_sel_e          sel;
  logic             run_go;
  logic             ras_under;
  logic             bad_align;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  assign pc_plus = pc + WIDTH'(INCR);
  assign run_go  = (state == RUN) && !stall;

  always_comb begin
    sel       = SEQ;
    ras_under = 1'b0;
    if (jmp_valid)                sel = JMP;
    else if (ret && !ras_empty)   sel = RET;
    else if (ret)                 ras_under = 1'b1;
    else if (br_taken)            sel = BR;

    case (sel)
      JMP:     target = jmp_target;
      RET:     target = ras_top;
      BR:      target = pc + br_offset;  // two's complement wraps to a signed offset
      default: target = pc_plus;
    endcase

    bad_align = (sel != SEQ) && ((target & LOW_MASK) != '0);
    next_pc   = target & ~LOW_MASK;
  end

  assign ras_push = run_go && jmp_valid && call;
  assign ras_pop  = run_go && (sel == RET);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
      ras_err  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      ras_err  <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            pc       <= next_pc;
            misalign <= bad_align;
            ras_err  <= ras_under && !ras_full;
            if (halt) begin
              state    <= HALT;
              pc_valid <= 1'b0;
            end
          end
        end
        HALT: begin
          if (resume) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, branches, wrap, calls/returns, alignment, stall, halt, reset.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, resume, br_taken, jmp_valid, call, ret;
  logic [31:0] br_offset, jmp_target;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, misalign, ras_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH        (32),
    .INCR         (4),
    .RESET_VECTOR (32'h0),
    .RAS_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .halt       (halt),
    .resume     (resume),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pc_plus    (pc_plus),
    .misalign   (misalign),
    .ras_err    (ras_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; halt = 0; resume = 0; br_taken = 0; jmp_valid = 0;
    call = 0; ret = 0; br_offset = '0; jmp_target = '0;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] rets [4];

  initial begin
    clr();
    rst_n = 1'b0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_raserr", {31'b0, ras_err}, 32'd0);
    rst_n = 1'b1;

    chk("boot_pc", pc, 32'h0);
    step();
    chk("run0_pc", pc, 32'h0);
    chk("run0_valid", {31'b0, pc_valid}, 32'd1);
    step();
    chk("run1_pc", pc, 32'h4);
    chk("run1_valid", {31'b0, pc_valid}, 32'd1);
    chk("pc_plus", pc_plus, 32'h8);
    step(); step(); step();
    chk("seq_pc", pc, 32'h10);

    br_taken = 1; br_offset = 32'hFFFF_FFF8;
    step();
    chk("br_back", pc, 32'h8);
    clr();

    jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
    step();
    chk("jmp_top", pc, 32'hFFFF_FFFC);
    clr();
    step();
    chk("wrap", pc, 32'h0);
    chk("wrap_mis", {31'b0, misalign}, 32'd0);

    jmp_valid = 1; jmp_target = 32'h20;
    step();
    jmp_valid = 1; call = 1; jmp_target = 32'h100;
    step();
    chk("call_pc", pc, 32'h100);
    clr(); ret = 1;
    step();
    chk("ret_pc", pc, 32'h24);
    chk("ret_err", {31'b0, ras_err}, 32'd0);
    clr();

    exp_pc = 32'h24;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) rets[i-1] = exp_pc + 32'h4;
      jmp_valid = 1; call = 1; jmp_target = 32'h200 + 32'(i) * 32'h100;
      step();
      exp_pc = jmp_target;
      chk("nest_call", pc, exp_pc);
    end
    clr(); ret = 1;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("nest_ret", pc, rets[i]);
      chk("nest_err", {31'b0, ras_err}, 32'd0);
    end
    step();
    chk("under_pc", pc, 32'h208);
    chk("under_err", {31'b0, ras_err}, 32'd1);
    clr();
    step();
    chk("under_clr", {31'b0, ras_err}, 32'd0);
    chk("under_seq", pc, 32'h20C);

    jmp_valid = 1; call = 1; jmp_target = 32'h700;
    step();
    clr(); jmp_valid = 1; ret = 1; br_taken = 1; jmp_target = 32'h40; br_offset = 32'h1000;
    step();
    chk("jrb_pc", pc, 32'h40);
    chk("jrb_mis", {31'b0, misalign}, 32'd0);
    jmp_target = 32'h43;
    step();
    chk("jmis_pc", pc, 32'h40);
    chk("jmis_mis", {31'b0, misalign}, 32'd1);
    clr(); ret = 1;
    step();
    chk("ras_kept", pc, 32'h210);
    chk("ras_kept_mis", {31'b0, misalign}, 32'd0);
    clr(); br_taken = 1; br_offset = 32'h6;
    step();
    chk("brmis_pc", pc, 32'h214);
    chk("brmis_mis", {31'b0, misalign}, 32'd1);
    clr();
    step();
    chk("brmis_seq", pc, 32'h218);

    stall = 1; br_taken = 1; br_offset = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h218);
      chk("stall_valid", {31'b0, pc_valid}, 32'd1);
    end
    stall = 0;
    step();
    chk("stall_br", pc, 32'h318);
    br_taken = 0;
    step();
    chk("stall_once", pc, 32'h31C);

    halt = 1;
    step();
    chk("halt_pc", pc, 32'h320);
    chk("halt_valid", {31'b0, pc_valid}, 32'd0);
    halt = 0; br_taken = 1; br_offset = 32'h40;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_hold", pc, 32'h320);
      chk("halt_hvalid", {31'b0, pc_valid}, 32'd0);
    end
    clr(); resume = 1;
    step();
    chk("resume_pc", pc, 32'h320);
    chk("resume_valid", {31'b0, pc_valid}, 32'd1);
    clr();
    step();
    chk("resume_seq", pc, 32'h324);

    halt = 1; jmp_valid = 1; call = 1; jmp_target = 32'h80;
    step();
    chk("halt_jmp_pc", pc, 32'h80);
    chk("halt_jmp_valid", {31'b0, pc_valid}, 32'd0);
    clr();
    step();
    chk("halt_jmp_hold", pc, 32'h80);

    #3 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'b0, pc_valid}, 32'd0);
    #2 rst_n = 1'b1;
    ret = 1;
    step();
    chk("reboot_pc", pc, 32'h0);
    chk("reboot_valid", {31'b0, pc_valid}, 32'd1);
    chk("reboot_err", {31'b0, ras_err}, 32'd0);
    step();
    chk("ras_flushed_pc", pc, 32'h4);
    chk("ras_flushed_err", {31'b0, ras_err}, 32'd1);
    clr();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
